control_unit: RTL
=================

Name: control_unit

Overview:
- Instruction sequencer directly upstream of the accumulator datapath.
- Fetches instruction words from a synchronous program memory, holds them in an instruction register, and decodes them through a multi-cycle FSM.
- Drives every datapath control input and the data-memory strobes.
- Takes the datapath's Z/N flags as inputs to resolve conditional branches.

Parameters:
- DATA_WIDTH, 11, operand width; equals the datapath width.
- OPCODE_WIDTH, 4, opcode field width.
- PC_WIDTH, 11, program counter and program address width.

Ports:
- clock_in  input  1  system clock, rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- instruction_in  input  OPCODE_WIDTH+DATA_WIDTH  program memory read data; opcode in the MSBs, operand in the LSBs.
- flag_Z_in  input  1  datapath zero flag.
- flag_N_in  input  1  datapath negative flag.
- program_address_out  output  PC_WIDTH  program memory address; equals PC.
- program_rd_out  output  1  program memory read strobe.
- operand_out  output  DATA_WIDTH  IR operand field; drives datapath operand_in.
- alu_op_out  output  1  0 = add, 1 = subtract.
- sel_A_out  output  2  accumulator source: 00 memory, 01 ext/immediate, 10 ALU.
- sel_B_out  output  1  ALU B source: 0 memory, 1 ext/immediate.
- acc_wr_out  output  1  accumulator write enable.
- status_wr_out  output  1  flag register write enable.
- acc_reset_out  output  1  accumulator clear.
- status_reset_out  output  1  flag clear.
- data_memory_rd_out  output  1  data memory read strobe.
- data_memory_wr_out  output  1  data memory write strobe; write data is the accumulator.
- halted_out  output  1  processor halted.

Behaviour:
- States: INIT, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- Outputs are decoded combinationally from the state and IR. No output is registered, except that program_address_out is the PC register.
- Reset (reset_in = 0), immediate and asynchronous:
  - state = INIT, PC = 0, IR = 0.
  - acc_reset_out = status_reset_out = 1.
  - All other strobes = 0; halted_out = 0; program_address_out = 0.
- INIT: one cycle after reset release, still asserting both resets, then -> FETCH.
- FETCH: program_rd_out = 1 with address = PC; -> DECODE.
- DECODE:
  - IR <= instruction_in (1-cycle memory latency).
  - PC <= PC + 1, wrapping 2^PC_WIDTH-1 -> 0.
  - -> EXECUTE.
- Opcodes and EXECUTE actions:
  - 0x0 HLT: -> HALT.
  - 0x1 STO: data_memory_wr_out = 1.
  - 0x2 LD: data_memory_rd_out = 1; -> WRITEBACK.
  - 0x3 LDI: sel_A = 01, acc_wr = 1.
  - 0x4 ADD: data_memory_rd_out = 1; -> WRITEBACK.
  - 0x5 ADDI: sel_B = 1, alu_op = 0, sel_A = 10, acc_wr = status_wr = 1.
  - 0x6 SUB: data_memory_rd_out = 1; -> WRITEBACK.
  - 0x7 SUBI: as ADDI with alu_op = 1.
  - 0x8 BEQ (Z), 0x9 BNE (!Z), 0xA BGT (!Z & !N), 0xB BGE (!N), 0xC BLT (N), 0xD BLE (N | Z), 0xE JMP (always): if the condition holds, PC <= operand[PC_WIDTH-1:0].
  - 0xF NOP: no action.
  - Unless noted otherwise, EXECUTE -> FETCH.
- WRITEBACK (memory data valid), then -> FETCH:
  - LD: sel_A = 00, acc_wr = 1.
  - ADD/SUB: sel_B = 0, sel_A = 10, alu_op per opcode, acc_wr = status_wr = 1.
- Latencies:
  - 3 cycles: STO, immediates, branches, NOP.
  - 4 cycles: LD, ADD, SUB.
- Flags are sampled in EXECUTE. They reflect the last ALU write, because that write completed in a prior cycle.
- operand_out = IR operand in every state; it is 0 after reset.
- HALT: halted_out = 1, all strobes 0, PC frozen; left only by reset.
- Reset asserted mid-instruction: any pending memory write or accumulator write is dropped in the same cycle. No partial instruction completes.
- A taken branch whose target equals the current instruction address loops indefinitely with no special handling.

Optional Feature:
- Macro: CONTROL_UNIT_STEP_EN.
- When defined:
  - Adds input step_in (1 bit).
  - The FSM stays in FETCH, with program_rd_out = 0, until step_in = 1 is sampled. It then issues the fetch and executes exactly one instruction.
  - Holding step_in high gives normal free-running operation.
- When undefined: the port is absent and FETCH always lasts one cycle.

Test Plan:
- Reset then release:
  - acc_reset_out = status_reset_out = 1 through INIT.
  - First program_rd_out with address 0 occurs on the 2nd clock after release.
- Program LDI 5; ADDI 3; STO 0x010; HLT:
  - Write strobe at data address 0x010; accumulator = 8.
  - halted_out = 1 after 3+3+3+3 cycles; PC frozen at 4.
- LD 0x020 (mem = 7); SUB 0x020; BEQ 0x00A:
  - The flag write gives Z = 1; branch taken.
  - Next fetch address = 0x00A; LD and SUB each take 4 cycles.
- SUBI 1 from accumulator 0 (N = 1, Z = 0), then BGE 0x100 then BLT 0x200:
  - BGE not taken; next fetch = PC+1.
  - BLT taken; next fetch = 0x200.
- PC = 0x7FF holding NOP: the following fetch address is 0x000.
- reset_in low during EXECUTE of STO:
  - data_memory_wr_out drops in the same cycle, PC = 0, state INIT.
  - With CONTROL_UNIT_STEP_EN, step_in = 0 keeps the FSM in FETCH with no read strobe. A single step_in pulse advances exactly one instruction.

Source files
------------

// File: rtl/control_unit.sv
// control_unit -- instruction sequencer for the accumulator datapath.
//
// Fetches instruction words from a synchronous program memory (one cycle of
// read latency), latches them into the instruction register and steps each
// instruction through INIT/FETCH/DECODE/EXECUTE/WRITEBACK/HALT. All datapath
// and data-memory controls are decoded combinationally from the state and IR;
// only the PC (program_address_out), IR and state are registered.
//
// Optional feature (macro CONTROL_UNIT_STEP_EN): adds step_in. FETCH waits,
// with no read strobe, until step_in = 1 is sampled, then runs one instruction.
//
// Ports:
//   clock_in             rising-edge clock
//   reset_in             asynchronous active-low reset
//   step_in              single-step enable (only with CONTROL_UNIT_STEP_EN)
//   instruction_in       program memory read data {opcode, operand}
//   flag_Z_in/flag_N_in  datapath zero / negative flags (sampled in EXECUTE)
//   program_address_out  PC
//   program_rd_out       program memory read strobe
//   operand_out          IR operand field
//   alu_op_out           0 add, 1 subtract
//   sel_A_out            accumulator source: 00 memory, 01 immediate, 10 ALU
//   sel_B_out            ALU B source: 0 memory, 1 immediate
//   acc_wr_out           accumulator write enable
//   status_wr_out        flag register write enable
//   acc_reset_out        accumulator clear
//   status_reset_out     flag clear
//   data_memory_rd_out   data memory read strobe
//   data_memory_wr_out   data memory write strobe (write data = accumulator)
//   halted_out           processor halted
//   state_out            current FSM state (debug visibility)
//
// Handshake: there is no valid/ready pair; memories are strobe-driven. A read
// strobe asserted in cycle N has its data valid throughout cycle N+1.

module control_unit #(
    parameter int DATA_WIDTH   = 11,
    parameter int OPCODE_WIDTH = 4,
    parameter int PC_WIDTH     = 11
) (
    input  logic                               clock_in,
    input  logic                               reset_in,
`ifdef CONTROL_UNIT_STEP_EN
    input  logic                               step_in,
`endif
    input  logic [OPCODE_WIDTH+DATA_WIDTH-1:0] instruction_in,
    input  logic                               flag_Z_in,
    input  logic                               flag_N_in,
    output logic [PC_WIDTH-1:0]                program_address_out,
    output logic                               program_rd_out,
    output logic [DATA_WIDTH-1:0]              operand_out,
    output logic                               alu_op_out,
    output logic [1:0]                         sel_A_out,
    output logic                               sel_B_out,
    output logic                               acc_wr_out,
    output logic                               status_wr_out,
    output logic                               acc_reset_out,
    output logic                               status_reset_out,
    output logic                               data_memory_rd_out,
    output logic                               data_memory_wr_out,
    output logic                               halted_out,
    output logic [2:0]                         state_out
);

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(4'h0);
    localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(4'h1);
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(4'h2);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(4'h3);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4'h4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(4'h5);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(4'h6);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(4'h7);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(4'h8);
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(4'h9);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGT  = OPCODE_WIDTH'(4'hA);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGE  = OPCODE_WIDTH'(4'hB);
    localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = OPCODE_WIDTH'(4'hC);
    localparam logic [OPCODE_WIDTH-1:0] OP_BLE  = OPCODE_WIDTH'(4'hD);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(4'hE);

    state_t                             state;
    state_t                             state_next;
    logic [PC_WIDTH-1:0]                pc;
    logic [OPCODE_WIDTH+DATA_WIDTH-1:0] ir;
    logic [OPCODE_WIDTH-1:0]            opcode;
    logic [DATA_WIDTH-1:0]              operand;
    logic [PC_WIDTH+DATA_WIDTH-1:0]     operand_ext;
    logic [PC_WIDTH-1:0]                branch_target;
    logic                               branch_taken;
    logic                               fetch_go;

    assign opcode  = ir[OPCODE_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign operand = ir[DATA_WIDTH-1:0];

    // Zero-extend first so the target slice is legal for any PC/data width mix.
    assign operand_ext   = {{PC_WIDTH{1'b0}}, operand};
    assign branch_target = operand_ext[PC_WIDTH-1:0];

    assign program_address_out = pc;
    assign operand_out         = operand;
    assign state_out           = state;

`ifdef CONTROL_UNIT_STEP_EN
    assign fetch_go = step_in;
`else
    assign fetch_go = 1'b1;
`endif

    // Branch condition; only meaningful while a branch opcode sits in EXECUTE.
    always_comb begin
        branch_taken = 1'b0;
        case (opcode)
            OP_BEQ:  branch_taken = flag_Z_in;
            OP_BNE:  branch_taken = !flag_Z_in;
            OP_BGT:  branch_taken = !flag_Z_in && !flag_N_in;
            OP_BGE:  branch_taken = !flag_N_in;
            OP_BLT:  branch_taken = flag_N_in;
            OP_BLE:  branch_taken = flag_N_in || flag_Z_in;
            OP_JMP:  branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state <= S_INIT;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                ir <= instruction_in;
                pc <= pc + PC_WIDTH'(1);
            end else if (state == S_EXECUTE && branch_taken) begin
                pc <= branch_target;
            end
        end
    end

    always_comb begin
        state_next         = state;
        program_rd_out     = 1'b0;
        alu_op_out         = 1'b0;
        sel_A_out          = 2'b00;
        sel_B_out          = 1'b0;
        acc_wr_out         = 1'b0;
        status_wr_out      = 1'b0;
        acc_reset_out      = 1'b0;
        status_reset_out   = 1'b0;
        data_memory_rd_out = 1'b0;
        data_memory_wr_out = 1'b0;
        halted_out         = 1'b0;

        case (state)
            S_INIT: begin
                acc_reset_out    = 1'b1;
                status_reset_out = 1'b1;
                state_next       = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_go) begin
                    program_rd_out = 1'b1;
                    state_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_next = S_FETCH;
                case (opcode)
                    OP_HLT: state_next = S_HALT;
                    OP_STO: data_memory_wr_out = 1'b1;
                    OP_LD, OP_ADD, OP_SUB: begin
                        data_memory_rd_out = 1'b1;
                        state_next         = S_WRITEBACK;
                    end
                    OP_LDI: begin
                        sel_A_out  = 2'b01;
                        acc_wr_out = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        sel_B_out     = 1'b1;
                        alu_op_out    = (opcode == OP_SUBI);
                        sel_A_out     = 2'b10;
                        acc_wr_out    = 1'b1;
                        status_wr_out = 1'b1;
                    end
                    default: ; // branches resolve in the PC register; NOP idles
                endcase
            end
            S_WRITEBACK: begin
                state_next = S_FETCH;
                if (opcode == OP_LD) begin
                    sel_A_out  = 2'b00;
                    acc_wr_out = 1'b1;
                end else begin
                    sel_B_out     = 1'b0;
                    sel_A_out     = 2'b10;
                    alu_op_out    = (opcode == OP_SUB);
                    acc_wr_out    = 1'b1;
                    status_wr_out = 1'b1;
                end
            end
            S_HALT: begin
                halted_out = 1'b1;
            end
            default: state_next = S_INIT;
        endcase
    end

endmodule
